// File: rtl/rv32im_csr_seq_pkg.sv
// ---------------------------------------------------------------------------
// rv32im_csr_seq_pkg
// Shared definitions for the CSR sequencer and its read-modify-write ALU:
//   - Zicsr funct3 codes and the two-bit ALU operation they reduce to
//   - machine-mode CSR addresses used by trap entry / mret
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - sequencer state encoding
// Optional build macro: CSR_SEQ_MTVAL_EN adds the T_TVAL state.
// ---------------------------------------------------------------------------
package rv32im_csr_seq_pkg;

   // Zicsr funct3 codes (bit 2 selects the immediate form).
   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   // The low two funct3 bits are identical for register and immediate forms.
   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   // Machine-mode CSR addresses.
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // mstatus bit positions.
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // Sequencer states: I_* instruction, T_* trap entry, M_* mret.
   typedef enum logic [4:0] {
      S_IDLE,
      S_I_RD,
      S_I_RDW,
      S_I_WR,
      S_I_RESP,
      S_T_EPC,
      S_T_CAUSE,
`ifdef CSR_SEQ_MTVAL_EN
      S_T_TVAL,
`endif
      S_T_ST_RD,
      S_T_ST_RDW,
      S_T_ST_WR,
      S_T_DONE,
      S_M_ST_RD,
      S_M_ST_RDW,
      S_M_ST_WR,
      S_M_EPC_RD,
      S_M_EPC_RDW,
      S_M_DONE
   } state_e;

   // funct3 000 and 100 are not Zicsr operations.
   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/rv32im_csr_alu.sv
// ---------------------------------------------------------------------------
// rv32im_csr_alu
// Combinational read-modify-write result for Zicsr instructions.
// Ports:
//   i_op     : funct3[1:0]  (01 write, 10 set bits, 11 clear bits)
//   i_old    : current CSR value (0 when the read was skipped)
//   i_wdata  : rs1 value or zero-extended zimm
//   o_result : value to write back
// ---------------------------------------------------------------------------
module rv32im_csr_alu
   import rv32im_csr_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_old,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_result
);

   always_comb begin
      o_result = i_wdata;
      case (i_op)
         OP_RS:   o_result = i_old | i_wdata;
         OP_RC:   o_result = i_old & ~i_wdata;
         default: o_result = i_wdata;
      endcase
   end

endmodule

// File: rtl/rv32im_csr_seq.sv
// ---------------------------------------------------------------------------
// rv32im_csr_seq
// Sequencer owning the single address/read/write port of the CSR register
// file. Serves three requesters, sampled only in IDLE with priority
// trap > mret > instruction:
//   - Zicsr read-modify-write (CSRRW/S/C and immediate forms)
//   - trap entry: mepc, mcause, (mtval), then mstatus update
//   - mret: mstatus restore, then mepc read returned on mret_pc_o
// Optional build macro: CSR_SEQ_MTVAL_EN. When defined, trap entry also
// writes mtval; when undefined trap_tval_i is ignored and trap entry is one
// cycle shorter.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   insn_*                  instruction request (valid/ready) and operands
//   rsp_*                   one-cycle completion pulse, old value, illegal flag
//   trap_*                  trap request (held until trap_done_o) and values
//   mret_*                  mret request (held until mret_done_o), mepc out
//   csr_addr_o/val_o        register file address / write data (0 when idle)
//   csr_we_o/re_o           write / read strobes
//   csr_val_i               read data, valid the cycle after csr_re_o
//   busy_o                  sequencer not in IDLE
//
// Handshake: an instruction is accepted on the rising edge where
// insn_valid_i and insn_ready_o are both high; operands are captured on that
// edge and may change afterwards. trap_valid_i / mret_valid_i are level
// requests held by the requester until the matching done pulse.
// ---------------------------------------------------------------------------
module rv32im_csr_seq
   import rv32im_csr_seq_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              insn_valid_i,
   output logic              insn_ready_o,
   input  logic [2:0]        insn_funct3_i,
   input  logic [CSR_AW-1:0] insn_addr_i,
   input  logic [XLEN-1:0]   insn_wdata_i,
   input  logic              insn_rs1_zero_i,
   input  logic              insn_rd_zero_i,
   output logic              rsp_valid_o,
   output logic [XLEN-1:0]   rsp_rdata_o,
   output logic              rsp_illegal_o,
   input  logic              trap_valid_i,
   input  logic [XLEN-1:0]   trap_cause_i,
   input  logic [XLEN-1:0]   trap_pc_i,
   input  logic [XLEN-1:0]   trap_tval_i,
   output logic              trap_done_o,
   input  logic              mret_valid_i,
   output logic              mret_done_o,
   output logic [XLEN-1:0]   mret_pc_o,
   output logic [CSR_AW-1:0] csr_addr_o,
   output logic [XLEN-1:0]   csr_val_o,
   output logic              csr_we_o,
   output logic              csr_re_o,
   input  logic [XLEN-1:0]   csr_val_i,
   output logic              busy_o
);

   state_e            r_state;
   state_e            w_next;

   logic [1:0]        r_op;
   logic [CSR_AW-1:0] r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_cap;
   logic              r_do_write;
   logic              r_illegal;

   logic              w_is_rw;
   logic              w_dec_read;
   logic              w_dec_write;
   logic              w_dec_illegal;
   logic              w_accept;
   logic              w_capture;
   logic [XLEN-1:0]   w_alu_result;
   logic [XLEN-1:0]   w_trap_ms;
   logic [XLEN-1:0]   w_mret_ms;

`ifndef CSR_SEQ_MTVAL_EN
   logic w_unused_tval;
   assign w_unused_tval = ^trap_tval_i;
`endif

   // ---------------------------------------------------------------------
   // Instruction decode (only meaningful in IDLE)
   // ---------------------------------------------------------------------
   // CSRRW/CSRRWI with rd=x0 must not read; set/clear forms with a zero
   // operand must not write.
   assign w_is_rw       = (insn_funct3_i[1:0] == OP_RW);
   assign w_dec_read    = !(w_is_rw && insn_rd_zero_i);
   assign w_dec_write   = w_is_rw || !insn_rs1_zero_i;
   // addr[top:top-1] == 11 marks the read-only CSR space; only an intended
   // write there is illegal.
   assign w_dec_illegal = !f3_legal(insn_funct3_i) ||
                          (w_dec_write && (insn_addr_i[CSR_AW-1 -: 2] == 2'b11));

   assign insn_ready_o  = (r_state == S_IDLE) && rst_n_i &&
                          !trap_valid_i && !mret_valid_i;
   assign w_accept      = insn_valid_i && insn_ready_o;
   assign busy_o        = (r_state != S_IDLE);

   // Read data is sampled at the end of every read-wait state.
   assign w_capture = (r_state == S_I_RDW)    || (r_state == S_T_ST_RDW) ||
                      (r_state == S_M_ST_RDW) || (r_state == S_M_EPC_RDW);

   rv32im_csr_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .i_op     (r_op),
      .i_old    (r_cap),
      .i_wdata  (r_wdata),
      .o_result (w_alu_result)
   );

   // mstatus images for trap entry and mret, built from the captured value.
   always_comb begin
      w_trap_ms                               = r_cap;
      w_trap_ms[MSTATUS_MPIE]                 = r_cap[MSTATUS_MIE];
      w_trap_ms[MSTATUS_MIE]                  = 1'b0;
      w_trap_ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      w_mret_ms                               = r_cap;
      w_mret_ms[MSTATUS_MIE]                  = r_cap[MSTATUS_MPIE];
      w_mret_ms[MSTATUS_MPIE]                 = 1'b1;
      w_mret_ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------
   // Operand / capture registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_op       <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cap      <= '0;
         r_do_write <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (w_accept) begin
         r_op       <= insn_funct3_i[1:0];
         r_addr     <= insn_addr_i;
         r_wdata    <= insn_wdata_i;
         // Cleared so a skipped read yields old value 0.
         r_cap      <= '0;
         r_do_write <= w_dec_write;
         r_illegal  <= w_dec_illegal;
      end else if (w_capture) begin
         r_cap      <= csr_val_i;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (trap_valid_i) begin
               w_next = S_T_EPC;
            end else if (mret_valid_i) begin
               w_next = S_M_ST_RD;
            end else if (insn_valid_i) begin
               if (w_dec_illegal) begin
                  w_next = S_I_RESP;
               end else if (w_dec_read) begin
                  w_next = S_I_RD;
               end else begin
                  w_next = S_I_WR;
               end
            end
         end
         S_I_RD:      w_next = S_I_RDW;
         S_I_RDW:     w_next = r_do_write ? S_I_WR : S_I_RESP;
         S_I_WR:      w_next = S_I_RESP;
         S_I_RESP:    w_next = S_IDLE;
         S_T_EPC:     w_next = S_T_CAUSE;
`ifdef CSR_SEQ_MTVAL_EN
         S_T_CAUSE:   w_next = S_T_TVAL;
         S_T_TVAL:    w_next = S_T_ST_RD;
`else
         S_T_CAUSE:   w_next = S_T_ST_RD;
`endif
         S_T_ST_RD:   w_next = S_T_ST_RDW;
         S_T_ST_RDW:  w_next = S_T_ST_WR;
         S_T_ST_WR:   w_next = S_T_DONE;
         S_T_DONE:    w_next = S_IDLE;
         S_M_ST_RD:   w_next = S_M_ST_RDW;
         S_M_ST_RDW:  w_next = S_M_ST_WR;
         S_M_ST_WR:   w_next = S_M_EPC_RD;
         S_M_EPC_RD:  w_next = S_M_EPC_RDW;
         S_M_EPC_RDW: w_next = S_M_DONE;
         S_M_DONE:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic: address and write data are driven only with a strobe.
   // ---------------------------------------------------------------------
   always_comb begin
      csr_addr_o    = '0;
      csr_val_o     = '0;
      csr_we_o      = 1'b0;
      csr_re_o      = 1'b0;
      rsp_valid_o   = 1'b0;
      rsp_rdata_o   = '0;
      rsp_illegal_o = 1'b0;
      trap_done_o   = 1'b0;
      mret_done_o   = 1'b0;
      mret_pc_o     = '0;
      case (r_state)
         S_I_RD: begin
            csr_re_o   = 1'b1;
            csr_addr_o = r_addr;
         end
         S_I_WR: begin
            csr_we_o   = 1'b1;
            csr_addr_o = r_addr;
            csr_val_o  = w_alu_result;
         end
         S_I_RESP: begin
            rsp_valid_o   = 1'b1;
            rsp_illegal_o = r_illegal;
            rsp_rdata_o   = r_illegal ? '0 : r_cap;
         end
         S_T_EPC: begin
            csr_we_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MEPC);
            csr_val_o  = trap_pc_i;
         end
         S_T_CAUSE: begin
            csr_we_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MCAUSE);
            csr_val_o  = trap_cause_i;
         end
`ifdef CSR_SEQ_MTVAL_EN
         S_T_TVAL: begin
            csr_we_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MTVAL);
            csr_val_o  = trap_tval_i;
         end
`endif
         S_T_ST_RD: begin
            csr_re_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MSTATUS);
         end
         S_T_ST_WR: begin
            csr_we_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MSTATUS);
            csr_val_o  = w_trap_ms;
         end
         S_T_DONE: begin
            trap_done_o = 1'b1;
         end
         S_M_ST_RD: begin
            csr_re_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MSTATUS);
         end
         S_M_ST_WR: begin
            csr_we_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MSTATUS);
            csr_val_o  = w_mret_ms;
         end
         S_M_EPC_RD: begin
            csr_re_o   = 1'b1;
            csr_addr_o = CSR_AW'(CSR_MEPC);
         end
         S_M_DONE: begin
            mret_done_o = 1'b1;
            mret_pc_o   = r_cap;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_rv32im_csr_seq.sv
module tb_rv32im_csr_seq;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n_i;
   logic        insn_valid_i, insn_ready_o;
   logic [2:0]  insn_funct3_i;
   logic [11:0] insn_addr_i;
   logic [31:0] insn_wdata_i;
   logic        insn_rs1_zero_i, insn_rd_zero_i;
   logic        rsp_valid_o, rsp_illegal_o;
   logic [31:0] rsp_rdata_o;
   logic        trap_valid_i, trap_done_o;
   logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
   logic        mret_valid_i, mret_done_o;
   logic [31:0] mret_pc_o;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_val_o, csr_val_i;
   logic        csr_we_o, csr_re_o, busy_o;

   rv32im_csr_seq #(.XLEN(32), .CSR_AW(12)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n_i),
      .insn_valid_i    (insn_valid_i),
      .insn_ready_o    (insn_ready_o),
      .insn_funct3_i   (insn_funct3_i),
      .insn_addr_i     (insn_addr_i),
      .insn_wdata_i    (insn_wdata_i),
      .insn_rs1_zero_i (insn_rs1_zero_i),
      .insn_rd_zero_i  (insn_rd_zero_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_rdata_o     (rsp_rdata_o),
      .rsp_illegal_o   (rsp_illegal_o),
      .trap_valid_i    (trap_valid_i),
      .trap_cause_i    (trap_cause_i),
      .trap_pc_i       (trap_pc_i),
      .trap_tval_i     (trap_tval_i),
      .trap_done_o     (trap_done_o),
      .mret_valid_i    (mret_valid_i),
      .mret_done_o     (mret_done_o),
      .mret_pc_o       (mret_pc_o),
      .csr_addr_o      (csr_addr_o),
      .csr_val_o       (csr_val_o),
      .csr_we_o        (csr_we_o),
      .csr_re_o        (csr_re_o),
      .csr_val_i       (csr_val_i),
      .busy_o          (busy_o)
   );

   // ---------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] rf   [4096];   // register file seen by the DUT
   logic [31:0] gold [4096];   // reference CSR contents
   logic [43:0] exp_q  [$];    // expected writes {addr, data}, in order
   logic [43:0] wr_log [$];    // observed committed writes
   int          rd_cnt;
   logic        mon_we = 1'b0, mon_re = 1'b0;
   logic [11:0] mon_addr = '0;
   logic [31:0] mon_val = '0;
   logic [11:0] addr_tab [8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'hC00, 12'hF14};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Register file model: strobes sampled mid-cycle, writes commit on the
   // following rising edge, read data presented for the cycle after re.
   always @(negedge clk) begin
      mon_we   = csr_we_o;
      mon_re   = csr_re_o;
      mon_addr = csr_addr_o;
      mon_val  = csr_val_o;
      if (!csr_we_o && !csr_re_o)
         check("bus_idle", {20'h0, csr_addr_o, csr_val_o}, 64'h0);
   end

   always @(posedge clk) begin
      if (rst_n_i && mon_we) begin
         wr_log.push_back({mon_addr, mon_val});
         rf[mon_addr] = mon_val;
      end
      if (rst_n_i && mon_re) rd_cnt++;
      #1;
      csr_val_i = (rst_n_i && mon_re) ? rf[mon_addr] : $urandom;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
      rf[a]   = v;
      gold[a] = v;
   endtask

   task automatic start_txn();
      rd_cnt = 0;
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic model_insn(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [31:0] wd, input logic rs1z, input logic rdz,
                             output int lat, output logic [31:0] rdata,
                             output logic ill, output int nrd);
      logic is_rw, is_rs, legal, do_rd, do_wr;
      logic [31:0] old, nv;
      legal = (f3 != 3'd0) && (f3 != 3'd4);
      is_rw = (f3 == 3'd1) || (f3 == 3'd5);
      is_rs = (f3 == 3'd2) || (f3 == 3'd6);
      do_rd = !(is_rw && rdz);
      do_wr = is_rw || !rs1z;
      ill   = !legal || (do_wr && addr >= 12'hC00);
      if (ill) begin
         lat = 1; rdata = 0; nrd = 0;
      end else begin
         old = do_rd ? gold[addr] : 32'h0;
         if (is_rw)      nv = wd;
         else if (is_rs) nv = old | wd;
         else            nv = old & ~wd;
         if (do_wr) begin
            gold[addr] = nv;
            exp_q.push_back({addr, nv});
         end
         rdata = old;
         nrd   = do_rd ? 1 : 0;
         lat   = 1 + (do_rd ? 2 : 0) + (do_wr ? 1 : 0);
      end
   endtask

   task automatic model_trap(input logic [31:0] cause, input logic [31:0] pc,
                             input logic [31:0] tval, output int lat);
      logic [31:0] ms, nv;
      gold[12'h341] = pc;    exp_q.push_back({12'h341, pc});
      gold[12'h342] = cause; exp_q.push_back({12'h342, cause});
`ifdef CSR_SEQ_MTVAL_EN
      gold[12'h343] = tval;  exp_q.push_back({12'h343, tval});
      lat = 7;
`else
      lat = 6;
`endif
      ms = gold[12'h300];
      nv = (ms & ~32'h0000_0088) | (((ms >> 3) & 32'h1) << 7) | 32'h0000_1800;
      gold[12'h300] = nv;
      exp_q.push_back({12'h300, nv});
   endtask

   task automatic model_mret(output int lat, output logic [31:0] pc);
      logic [31:0] ms, nv;
      ms = gold[12'h300];
      nv = (ms & ~32'h0000_0088) | (((ms >> 7) & 32'h1) << 3) | 32'h0000_1880;
      gold[12'h300] = nv;
      exp_q.push_back({12'h300, nv});
      pc  = gold[12'h341];
      lat = 6;
   endtask

   // ---------------------------------------------------------------------
   // Drivers (called at a falling edge)
   // ---------------------------------------------------------------------
   task automatic drive_insn(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [31:0] wd, input logic rs1z, input logic rdz,
                             output int lat, output logic [31:0] rdata, output logic ill);
      int guard;
      lat = 0; rdata = 0; ill = 0;
      insn_funct3_i = f3; insn_addr_i = addr; insn_wdata_i = wd;
      insn_rs1_zero_i = rs1z; insn_rd_zero_i = rdz; insn_valid_i = 1'b1;
      #1;
      guard = 0;
      while (!insn_ready_o && guard < 60) begin
         @(negedge clk); #1; guard++;
      end
      if (!insn_ready_o) begin
         check("insn_accept", 64'(insn_ready_o), 64'h1);
         insn_valid_i = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      insn_valid_i  = 1'b0;
      insn_funct3_i = 3'($urandom); insn_addr_i = 12'($urandom); insn_wdata_i = $urandom;
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) @(negedge clk);
         if (rsp_valid_o) begin
            lat = i; rdata = rsp_rdata_o; ill = rsp_illegal_o;
            break;
         end
      end
   endtask

   task automatic drive_trap(input logic [31:0] cause, input logic [31:0] pc,
                             input logic [31:0] tval, output int lat);
      lat = 0;
      trap_cause_i = cause; trap_pc_i = pc; trap_tval_i = tval; trap_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) @(negedge clk);
         if (trap_done_o) begin
            lat = i;
            break;
         end
      end
      trap_valid_i = 1'b0;
   endtask

   task automatic drive_mret(output int lat, output logic [31:0] pc);
      lat = 0; pc = 0;
      mret_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) @(negedge clk);
         if (mret_done_o) begin
            lat = i; pc = mret_pc_o;
            break;
         end
      end
      mret_valid_i = 1'b0;
   endtask

   task automatic check_log(input int exp_rd);
      check("rd_count", 64'(rd_cnt), 64'(exp_rd));
      check("wr_count", 64'(wr_log.size()), 64'(exp_q.size()));
      for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
         check("wr_data", 64'(wr_log[i]), 64'(exp_q[i]));
   endtask

   task automatic post_idle();
      @(negedge clk);
      check("post_idle", {58'h0, rsp_valid_o, trap_done_o, mret_done_o, busy_o,
                          csr_we_o, csr_re_o}, 64'h0);
   endtask

   task automatic run_insn(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] wd, input logic rs1z, input logic rdz);
      int elat, lat, nrd;
      logic [31:0] erd, rd;
      logic eill, ill;
      start_txn();
      model_insn(f3, addr, wd, rs1z, rdz, elat, erd, eill, nrd);
      drive_insn(f3, addr, wd, rs1z, rdz, lat, rd, ill);
      check("insn_lat", 64'(lat), 64'(elat));
      check("insn_rdata", 64'(rd), 64'(erd));
      check("insn_illegal", 64'(ill), 64'(eill));
      post_idle();
      check_log(nrd);
   endtask

   task automatic run_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
      int elat, lat;
      start_txn();
      model_trap(cause, pc, tval, elat);
      drive_trap(cause, pc, tval, lat);
      check("trap_lat", 64'(lat), 64'(elat));
      post_idle();
      check_log(1);
   endtask

   task automatic run_mret();
      int elat, lat;
      logic [31:0] epc, pc;
      start_txn();
      model_mret(elat, epc);
      drive_mret(lat, pc);
      check("mret_lat", 64'(lat), 64'(elat));
      check("mret_pc", 64'(pc), 64'(epc));
      post_idle();
      check_log(2);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin : main
      int tlat_e, tlat, ilat_e, ilat, nrd;
      logic [31:0] ird_e, ird;
      logic ill_e, ill;

      rst_n_i = 1'b0;
      insn_valid_i = 0; insn_funct3_i = 0; insn_addr_i = 0; insn_wdata_i = 0;
      insn_rs1_zero_i = 0; insn_rd_zero_i = 0;
      trap_valid_i = 0; trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
      mret_valid_i = 0; csr_val_i = 0;
      for (int i = 0; i < 4096; i++) begin rf[i] = 0; gold[i] = 0; end
      for (int i = 0; i < 8; i++) set_csr(addr_tab[i], $urandom);

      // Reset state
      #1;
      check("reset_bus", {18'h0, csr_re_o, csr_we_o, csr_addr_o, csr_val_o}, 64'h0);
      check("reset_ctl", {58'h0, rsp_valid_o, rsp_illegal_o, trap_done_o, mret_done_o,
                          busy_o, insn_ready_o}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n_i = 1'b1;
      @(negedge clk); #1;
      check("ready_after_reset", {62'h0, busy_o, insn_ready_o}, 64'h1);
      @(negedge clk);

      // CSRRW mstatus
      set_csr(12'h300, 32'h0000_1800);
      run_insn(3'b001, 12'h300, 32'h8, 1'b0, 1'b0);
      check("tp_rw_mstatus", 64'(rf[12'h300]), 64'h8);
      // CSRRS mcycle with rs1 zero: read only
      run_insn(3'b010, 12'hB00, 32'h0, 1'b1, 1'b0);
      // CSRRC mstatus
      set_csr(12'h300, 32'h0000_0088);
      run_insn(3'b011, 12'h300, 32'h8, 1'b0, 1'b0);
      check("tp_rc_mstatus", 64'(rf[12'h300]), 64'h80);
      // CSRRWI with rd=x0: write only
      run_insn(3'b101, 12'h340, 32'h1F, 1'b0, 1'b1);
      // Illegal: write to read-only, funct3 100, funct3 000
      run_insn(3'b001, 12'hC00, 32'h5, 1'b0, 1'b0);
      run_insn(3'b100, 12'h300, 32'h1, 1'b0, 1'b0);
      run_insn(3'b000, 12'h305, 32'h1, 1'b0, 1'b0);
      // Set with zero operand on read-only CSR is a legal read
      run_insn(3'b110, 12'hF14, 32'h0, 1'b1, 1'b0);

      // Trap arriving together with an instruction: trap wins, insn waits
      set_csr(12'h300, 32'h0000_0088);
      start_txn();
      model_trap(32'hB, 32'h8000_0100, 32'hDEAD_BEEF, tlat_e);
      model_insn(3'b010, 12'h300, 32'h0, 1'b1, 1'b0, ilat_e, ird_e, ill_e, nrd);
      fork
         drive_trap(32'hB, 32'h8000_0100, 32'hDEAD_BEEF, tlat);
         begin
            #1;
            check("ready_vs_trap", 64'(insn_ready_o), 64'h0);
            drive_insn(3'b010, 12'h300, 32'h0, 1'b1, 1'b0, ilat, ird, ill);
         end
      join
      check("trap_lat", 64'(tlat), 64'(tlat_e));
      check("queued_insn_lat", 64'(ilat), 64'(ilat_e));
      check("queued_insn_rdata", 64'(ird), 64'(ird_e));
      check("tp_trap_mstatus", 64'(rf[12'h300]), 64'h1880);
      post_idle();
      check_log(1 + nrd);

      // mret
      set_csr(12'h300, 32'h0000_1880);
      set_csr(12'h341, 32'h8000_0104);
      run_mret();
      check("tp_mret_mstatus", 64'(rf[12'h300]), 64'h1888);

      // Reset in T_CAUSE
      start_txn();
      trap_cause_i = 32'h7; trap_pc_i = 32'h8000_0200; trap_tval_i = 32'h1234;
      trap_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);   // T_EPC
      @(negedge clk);   // T_CAUSE
      #2;
      rst_n_i = 1'b0; trap_valid_i = 1'b0;
      #1;
      check("midrst_bus", {18'h0, csr_re_o, csr_we_o, csr_addr_o, csr_val_o}, 64'h0);
      check("midrst_ctl", {58'h0, rsp_valid_o, rsp_illegal_o, trap_done_o, mret_done_o,
                           busy_o, insn_ready_o}, 64'h0);
      check("midrst_data", {rsp_rdata_o, mret_pc_o}, 64'h0);
      repeat (3) begin
         @(negedge clk); #1;
         check("in_reset_strobes", {62'h0, csr_we_o, csr_re_o}, 64'h0);
      end
      @(negedge clk);
      rst_n_i = 1'b1;
      @(negedge clk); #1;
      check("idle_after_midrst", {62'h0, busy_o, insn_ready_o}, 64'h1);
      gold[12'h341] = 32'h8000_0200;
      exp_q.push_back({12'h341, 32'h8000_0200});
      check_log(0);
      @(negedge clk);

      // Randomized mix
      for (int n = 0; n < 150; n++) begin
         int kind;
         kind = $urandom_range(0, 99);
         if (kind < 80) begin
            logic [2:0] f3;
            logic [11:0] a;
            logic rs1z, rdz;
            logic [31:0] wd;
            f3   = 3'($urandom_range(0, 7));
            a    = addr_tab[$urandom_range(0, 7)];
            rs1z = ($urandom_range(0, 3) == 0);
            rdz  = ($urandom_range(0, 3) == 0);
            wd   = rs1z ? 32'h0 : $urandom;
            run_insn(f3, a, wd, rs1z, rdz);
         end else if (kind < 90) begin
            run_trap($urandom, $urandom, $urandom);
         end else begin
            run_mret();
         end
      end

      for (int i = 0; i < 8; i++)
         check("final_csr", 64'(rf[addr_tab[i]]), 64'(gold[addr_tab[i]]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv32im_csr_seq.md
Name: rv32im_csr_seq

Overview:
- Sequencer between the pipeline and the rv32im_csr register file. It owns the register file's single address/read/write port.
- Performs read-modify-write for Zicsr instructions (CSRRW/S/C and immediate forms).
- Performs the multi-register trap-entry writes (mepc, mcause, mtval, mstatus) and the mret mstatus restore.
- Arbitrates between three requesters: trap, mret and instruction.

Parameters:
XLEN, 32, data width (matches `API_XLEN)
CSR_AW, 12, CSR address width (matches `CSR_WIDTH)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
insn_valid_i  in  1  CSR instruction request
insn_ready_o  out  1  request accepted when valid&ready
insn_funct3_i  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
insn_addr_i  in  CSR_AW  CSR address
insn_wdata_i  in  XLEN  rs1 value or zero-extended zimm (pre-muxed)
insn_rs1_zero_i  in  1  rs1 index / zimm is zero
insn_rd_zero_i  in  1  rd is x0
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  XLEN  old CSR value (0 when read skipped)
rsp_illegal_o  out  1  illegal access, qualified by rsp_valid_o
trap_valid_i  in  1  trap entry; held until trap_done_o
trap_cause_i  in  XLEN  mcause value
trap_pc_i  in  XLEN  mepc value
trap_tval_i  in  XLEN  mtval value
trap_done_o  out  1  one-cycle pulse
mret_valid_i  in  1  mret request; held until mret_done_o
mret_done_o  out  1  one-cycle pulse
mret_pc_o  out  XLEN  mepc read during mret, valid with mret_done_o
csr_addr_o  out  CSR_AW  to register file
csr_val_o  out  XLEN  write data to register file
csr_we_o  out  1  write strobe
csr_re_o  out  1  read strobe
csr_val_i  in  XLEN  read data, valid the cycle after csr_re_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset: async, rst_n_i low forces IDLE.
  - All outputs are 0 except insn_ready_o, which is 1 in IDLE once reset is released.
  - Reset mid-sequence abandons the sequence. Writes already issued persist; no further strobes are issued.
- Arbitration is sampled only in IDLE. Priority: trap > mret > insn.
  - insn_ready_o = IDLE & !trap_valid_i & !mret_valid_i.
- Instruction path:
  - States: IDLE -> RD -> RDW -> WR -> RESP -> IDLE.
  - RD: csr_re_o=1. RDW: capture csr_val_i. WR: csr_we_o=1. RESP: rsp_valid_o=1.
  - Read is skipped (rdata=0) for RW/RWI with rd_zero: IDLE -> WR -> RESP.
  - Write is skipped for RS/RC/RSI/RCI with rs1_zero: IDLE -> RD -> RDW -> RESP.
  - Full op: rsp_valid_o asserted 4 cycles after the accept edge.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. For RW with skipped read, old is 0.
- Illegal access:
  - Write intended to addr[11:10]==2'b11 (read-only), or funct3 000/100.
  - Sequence: IDLE -> RESP with rsp_illegal_o=1, rdata 0, no re/we.
- Trap sequence, one write per cycle:
  - T_EPC (0x341 <= pc), T_CAUSE (0x342 <= cause), T_TVAL (0x343 <= tval).
  - T_ST_RD, T_ST_RDW, then T_ST_WR writes mstatus with MPIE(7) <= MIE(3), MIE <= 0, MPP(12:11) <= 11.
  - Then T_DONE: trap_done_o=1, return to IDLE.
- mret sequence:
  - M_ST_RD, M_ST_RDW, then M_ST_WR writes mstatus with MIE <= MPIE, MPIE <= 1, MPP <= 11.
  - M_EPC_RD, M_EPC_RDW capture mepc.
  - M_DONE: mret_done_o=1, mret_pc_o = captured mepc.
- csr_val_o and csr_addr_o are 0 when no strobe is active.
- Requests arriving while busy wait; they are not lost.

Optional Feature:
- CSR_SEQ_MTVAL_EN.
- Defined: T_TVAL state is present and mtval is written.
- Undefined: T_TVAL is removed, trap_tval_i is ignored, and trap_done_o arrives one cycle earlier (6 cycles after start instead of 7).

Decomposition:
- Shared DEFINITIONS package holds:
  - funct3 codes;
  - CSR addresses (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343);
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11);
  - state encodings.
- One combinational sub-module, rv32im_csr_alu, computes the RW/RS/RC result.

Test Plan:
- CSRRW 0x300, mstatus=0x00001800, wdata 0x8 -> one re, one we with val 0x00000008, rsp_rdata 0x00001800, rsp_valid_o 4 cycles after accept.
- CSRRS mcycle with rs1_zero=1 -> csr_we_o never high, rsp 3 cycles after accept. CSRRC mstatus=0x88 with wdata 0x8 -> write 0x00000080.
- CSRRW to 0xC00 -> rsp_illegal_o=1, no re/we, rsp 1 cycle after accept. funct3=100 -> illegal as well.
- Trap cause 0xB, pc 0x80000100, mstatus 0x88 -> writes mepc/mcause/(mtval) in order, mstatus 0x00001880, trap_done_o pulse. insn_valid_i asserted in the same cycle sees insn_ready_o=0 and is served afterwards.
- mret with mstatus 0x1880, mepc 0x80000104 -> mstatus 0x00001888, mret_pc_o 0x80000104 with mret_done_o.
- Reset asserted in T_CAUSE -> no further strobes, all outputs 0 immediately, IDLE after release.
